// File: rtl/fp_wire.sv
// -----------------------------------------------------------------------------
// fp_wire
//   Shared types and constants for the single-precision FP execute unit:
//   the one-hot operation bundle, rounding-mode and compare-selector
//   encodings, exception-flag bit positions, conversion type encodings, and
//   the rounding-increment decision shared by both conversion directions.
// -----------------------------------------------------------------------------
package fp_wire;

    typedef struct packed {
        logic       fmadd;
        logic       fadd;
        logic       fsub;
        logic       fmul;
        logic       fdiv;
        logic       fsqrt;
        logic       fcmp;
        logic       fcvt_i2f;
        logic       fcvt_f2i;
        logic [1:0] fcvt_op;
    } fp_operation_type;

    localparam fp_operation_type init_fp_operation = '0;

    // Rounding modes; encodings 5..7 fall back to round-to-nearest-even.
    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_type;

    // Compare selector carried on rm during fcmp.
    localparam logic [2:0] CMP_FLE = 3'd0;
    localparam logic [2:0] CMP_FLT = 3'd1;
    localparam logic [2:0] CMP_FEQ = 3'd2;

    // fcvt_op encodings; 2 and 3 behave as signed.
    localparam logic [1:0] FCVT_I32 = 2'd0;
    localparam logic [1:0] FCVT_U32 = 2'd1;

    // Flag vector is {NV,DZ,OF,UF,NX}.
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Decide whether the kept magnitude must be incremented by one ulp.
    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic lsb, input logic guard,
                                       input logic sticky);
        case (rm)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign & (guard | sticky);
            RM_RUP:  return ~sign & (guard | sticky);
            RM_RMM:  return guard;
            default: return guard & (sticky | lsb);
        endcase
    endfunction

endpackage

// File: rtl/fp_unit_sp_if.sv
// -----------------------------------------------------------------------------
// fp_unit_sp_if
//   Operation/result bundle between the FP execute stage and fp_unit_sp.
//   master: issues data1..3, fmt, rm, op, enable; receives result, flags.
//   slave : the execution unit side.
// -----------------------------------------------------------------------------
interface fp_unit_sp_if;
    import fp_wire::*;

    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    fp_operation_type op;
    logic             enable;
    logic [31:0]      result;
    logic [4:0]       flags;

    modport master (output data1, data2, data3, fmt, rm, op, enable,
                    input  result, flags);
    modport slave  (input  data1, data2, data3, fmt, rm, op, enable,
                    output result, flags);
endinterface

// File: rtl/fp_cvt.sv
// -----------------------------------------------------------------------------
// fp_cvt
//   Combinational binary32 <-> 32-bit integer conversion.
//   src         : integer source (i2f) or float source (f2i)
//   is_unsigned : integer side is u32 rather than i32
//   rm          : rounding mode
//   i2f_result/i2f_flags, f2i_result/f2i_flags : both directions in parallel
// -----------------------------------------------------------------------------
module fp_cvt
    import fp_wire::*;
(
    input  logic [31:0] src,
    input  logic        is_unsigned,
    input  logic [2:0]  rm,
    output logic [31:0] i2f_result,
    output logic [4:0]  i2f_flags,
    output logic [31:0] f2i_result,
    output logic [4:0]  f2i_flags
);

    function automatic logic [4:0] lzc32(input logic [31:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // ---------------- integer -> float ----------------
    logic        i_sign, i_guard, i_sticky, i_inc;
    logic [31:0] i_mag, i_norm;
    logic [4:0]  i_lz;
    logic [24:0] i_sum;
    logic [7:0]  i_exp;

    // NOTE: every variable assigned in an always_comb gets a value on every
    // path (defaults first); a missed path would infer a latch.
    always_comb begin
        i_sign     = ~is_unsigned & src[31];
        i_mag      = i_sign ? -src : src;
        i_lz       = lzc32(i_mag);
        i_norm     = i_mag << i_lz;
        // Keep 24 bits after the leading one; bit 7 is guard, below is sticky.
        i_guard    = i_norm[7];
        i_sticky   = |i_norm[6:0];
        i_inc      = round_inc(rm, i_sign, i_norm[8], i_guard, i_sticky);
        i_sum      = {1'b0, i_norm[31:8]} + {24'b0, i_inc};
        // Bias 127 + 31 for a leading one at bit 31; mantissa carry adds one.
        i_exp      = 8'd158 - {3'b0, i_lz} + {7'b0, i_sum[24]};
        i2f_result = 32'h0;
        i2f_flags  = 5'h0;
        if (i_mag != 32'h0) begin
            i2f_result         = {i_sign, i_exp, i_sum[24] ? i_sum[23:1] : i_sum[22:0]};
            i2f_flags[FLAG_NX] = i_guard | i_sticky;
        end
    end

    // ---------------- float -> integer ----------------
    logic        f_sign, f_nan, f_big, f_guard, f_sticky, f_inc, f_inexact;
    logic [7:0]  f_exp;
    logic [23:0] f_mant;
    logic [48:0] f_wide;
    logic [32:0] f_int, f_rnd;

    always_comb begin
        f_sign   = src[31];
        f_exp    = src[30:23];
        // Denormals get no hidden bit; they only ever feed the sticky bit.
        f_mant   = {|f_exp, src[22:0]};
        f_nan    = (&f_exp) & (|src[22:0]);
        f_big    = 1'b0;
        f_int    = 33'h0;
        f_guard  = 1'b0;
        f_sticky = 1'b0;
        f_wide   = 49'h0;
        if (f_exp >= 8'd150) begin
            // Integer-valued; beyond 2^31 * 2 magnitude it can never fit.
            if (f_exp > 8'd158) f_big = 1'b1;
            else                f_int = {9'b0, f_mant} << (f_exp - 8'd150);
        end else if (f_exp < 8'd125) begin
            // Below 0.5: nothing reaches the guard position.
            f_sticky = |f_mant;
        end else begin
            f_wide   = {f_mant, 25'b0} >> (8'd150 - f_exp);
            f_int    = {9'b0, f_wide[48:25]};
            f_guard  = f_wide[24];
            f_sticky = |f_wide[23:0];
        end
        f_inc     = round_inc(rm, f_sign, f_int[0], f_guard, f_sticky);
        f_rnd     = f_int + {32'b0, f_inc};
        f_inexact = f_guard | f_sticky;

        f2i_result = 32'h0;
        f2i_flags  = 5'h0;
        if (f_nan) begin
            f2i_result         = is_unsigned ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            f2i_flags[FLAG_NV] = 1'b1;
        end else if (is_unsigned) begin
            if (f_sign) begin
                // Negative input is only legal if it rounds to zero.
                if (f_big || f_rnd != 33'h0) f2i_flags[FLAG_NV] = 1'b1;
                else                         f2i_flags[FLAG_NX] = f_inexact;
            end else if (f_big || f_rnd[32]) begin
                f2i_result         = 32'hFFFF_FFFF;
                f2i_flags[FLAG_NV] = 1'b1;
            end else begin
                f2i_result         = f_rnd[31:0];
                f2i_flags[FLAG_NX] = f_inexact;
            end
        end else begin
            if (f_big || f_rnd > (f_sign ? 33'h0_8000_0000 : 33'h0_7FFF_FFFF)) begin
                f2i_result         = f_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                f2i_flags[FLAG_NV] = 1'b1;
            end else begin
                f2i_result         = f_sign ? -f_rnd[31:0] : f_rnd[31:0];
                f2i_flags[FLAG_NX] = f_inexact;
            end
        end
    end

endmodule

// File: rtl/fp_unit_sp.sv
// -----------------------------------------------------------------------------
// fp_unit_sp
//   Single-precision FP execute unit: compare (FLE/FLT/FEQ) and int<->float
//   conversion, one operation per cycle, registered result one cycle later.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears result/flags
//   bus   : fp_unit_sp_if slave (operands, rm, op, enable in; result, flags out)
//   Build option FP_UNIT_ONEHOT_CHECK_EN: multiple op bits with enable
//   produce result 0 and flags NV instead of fcmp > i2f > f2i priority.
// -----------------------------------------------------------------------------
module fp_unit_sp
    import fp_wire::*;
(
    input  logic         clock,
    input  logic         reset,
    fp_unit_sp_if.slave  bus
);

    // data3 and fmt are part of the bus but carry nothing for these ops.
    logic unused_inputs;
    assign unused_inputs = ^{bus.data3, bus.fmt};

    logic [31:0] i2f_result, f2i_result;
    logic [4:0]  i2f_flags, f2i_flags;

    fp_cvt u_cvt (
        .src         (bus.data1),
        .is_unsigned (bus.op.fcvt_op == FCVT_U32),
        .rm          (bus.rm),
        .i2f_result  (i2f_result),
        .i2f_flags   (i2f_flags),
        .f2i_result  (f2i_result),
        .f2i_flags   (f2i_flags)
    );

    // ---------------- compare ----------------
    logic        a_nan, b_nan, any_snan, both_zero, cmp_eq, cmp_lt;
    logic [31:0] cmp_result;
    logic [4:0]  cmp_flags;

    always_comb begin
        a_nan     = (&bus.data1[30:23]) & (|bus.data1[22:0]);
        b_nan     = (&bus.data2[30:23]) & (|bus.data2[22:0]);
        // Signalling NaNs have the quiet bit (mantissa MSB) clear.
        any_snan  = (a_nan & ~bus.data1[22]) | (b_nan & ~bus.data2[22]);
        both_zero = (bus.data1[30:0] | bus.data2[30:0]) == 31'h0;
        cmp_eq    = (bus.data1 == bus.data2) | both_zero;
        // Sign-magnitude ordering; negative magnitudes compare reversed.
        if (both_zero)                     cmp_lt = 1'b0;
        else if (bus.data1[31] != bus.data2[31]) cmp_lt = bus.data1[31];
        else if (bus.data1[31])            cmp_lt = bus.data1[30:0] > bus.data2[30:0];
        else                               cmp_lt = bus.data1[30:0] < bus.data2[30:0];
        cmp_result = 32'h0;
        cmp_flags  = 5'h0;
        if (a_nan || b_nan) begin
            if (bus.rm == CMP_FEQ)                           cmp_flags[FLAG_NV] = any_snan;
            else if (bus.rm == CMP_FLE || bus.rm == CMP_FLT) cmp_flags[FLAG_NV] = 1'b1;
        end else begin
            case (bus.rm)
                CMP_FLE: cmp_result[0] = cmp_lt | cmp_eq;
                CMP_FLT: cmp_result[0] = cmp_lt;
                CMP_FEQ: cmp_result[0] = cmp_eq;
                default: cmp_result[0] = 1'b0;
            endcase
        end
    end

    // ---------------- op select ----------------
    logic multi_op;
`ifdef FP_UNIT_ONEHOT_CHECK_EN
    assign multi_op = $countones({bus.op.fmadd, bus.op.fadd, bus.op.fsub,
                                  bus.op.fmul, bus.op.fdiv, bus.op.fsqrt,
                                  bus.op.fcmp, bus.op.fcvt_i2f, bus.op.fcvt_f2i}) > 1;
`else
    assign multi_op = 1'b0;
`endif

    logic [31:0] next_result;
    logic [4:0]  next_flags;

    always_comb begin
        next_result = 32'h0;
        next_flags  = 5'h0;
        if (bus.enable) begin
            if (multi_op) begin
                next_flags[FLAG_NV] = 1'b1;
            end else if (bus.op.fcmp) begin
                next_result = cmp_result;
                next_flags  = cmp_flags;
            end else if (bus.op.fcvt_i2f) begin
                next_result = i2f_result;
                next_flags  = i2f_flags;
            end else if (bus.op.fcvt_f2i) begin
                next_result = f2i_result;
                next_flags  = f2i_flags;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.result <= 32'h0;
            bus.flags  <= 5'h0;
        end else begin
            bus.result <= next_result;
            bus.flags  <= next_flags;
        end
    end

endmodule

// File: tb/tb_fp_unit_sp.sv
module tb_fp_unit_sp;
    import fp_wire::*;

    logic clock = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    fp_unit_sp_if bus ();

    fp_unit_sp dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic fp_operation_type mk(input logic cmp, input logic i2f,
                                            input logic f2i, input logic [1:0] cop);
        fp_operation_type o;
        o          = init_fp_operation;
        o.fcmp     = cmp;
        o.fcvt_i2f = i2f;
        o.fcvt_f2i = f2i;
        o.fcvt_op  = cop;
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] exp_r, input logic [4:0] exp_f);
        compared++;
        assert (bus.result === exp_r) else begin
            mismatched++;
            $error("FAIL %s result: observed %08h expected %08h", tag, bus.result, exp_r);
        end
        compared++;
        assert (bus.flags === exp_f) else begin
            mismatched++;
            $error("FAIL %s flags: observed %02h expected %02h", tag, bus.flags, exp_f);
        end
    endtask

    // Drive at negedge, let one rising edge capture, sample 1 time unit later.
    task automatic issue(input fp_operation_type op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] rm, input logic en);
        @(negedge clock);
        bus.op     = op;
        bus.data1  = a;
        bus.data2  = b;
        bus.rm     = rm;
        bus.enable = en;
        @(posedge clock);
        #1;
    endtask

    initial begin
        fp_operation_type op_cmp, op_i2f, op_u2f, op_f2i, op_f2u, op_f2i_c2;
        fp_operation_type op_fadd, op_two;
        op_cmp    = mk(1'b1, 1'b0, 1'b0, 2'd0);
        op_i2f    = mk(1'b0, 1'b1, 1'b0, 2'd0);
        op_u2f    = mk(1'b0, 1'b1, 1'b0, 2'd1);
        op_f2i    = mk(1'b0, 1'b0, 1'b1, 2'd0);
        op_f2u    = mk(1'b0, 1'b0, 1'b1, 2'd1);
        op_f2i_c2 = mk(1'b0, 1'b0, 1'b1, 2'd2);
        op_fadd   = init_fp_operation;
        op_fadd.fadd = 1'b1;
        op_two    = mk(1'b1, 1'b1, 1'b0, 2'd0);

        bus.data1  = 32'h0;
        bus.data2  = 32'h0;
        bus.data3  = 32'h0;
        bus.fmt    = 2'd0;
        bus.rm     = 3'd0;
        bus.op     = init_fp_operation;
        bus.enable = 1'b0;
        reset      = 1'b1;
        #12;
        check("reset", 32'h0, 5'h00);
        @(negedge clock);
        reset = 1'b0;

        // Compare
        issue(op_cmp, 32'h3F800000, 32'h40000000, 3'd1, 1'b1); check("flt_1_2", 32'h1, 5'h00);
        issue(op_cmp, 32'h40000000, 32'h3F800000, 3'd1, 1'b1); check("flt_2_1", 32'h0, 5'h00);
        issue(op_cmp, 32'h00000000, 32'h80000000, 3'd0, 1'b1); check("fle_pz_nz", 32'h1, 5'h00);
        issue(op_cmp, 32'h80000000, 32'h00000000, 3'd1, 1'b1); check("flt_nz_pz", 32'h0, 5'h00);
        issue(op_cmp, 32'h80000000, 32'h00000000, 3'd2, 1'b1); check("feq_nz_pz", 32'h1, 5'h00);
        issue(op_cmp, 32'hC0000000, 32'hBF800000, 3'd1, 1'b1); check("flt_neg", 32'h1, 5'h00);
        issue(op_cmp, 32'h7FA00000, 32'h3F800000, 3'd2, 1'b1); check("feq_snan", 32'h0, 5'h10);
        issue(op_cmp, 32'h7FC00000, 32'h3F800000, 3'd2, 1'b1); check("feq_qnan", 32'h0, 5'h00);
        issue(op_cmp, 32'h7FC00000, 32'h3F800000, 3'd1, 1'b1); check("flt_qnan", 32'h0, 5'h10);
        issue(op_cmp, 32'h3F800000, 32'h3F800000, 3'd3, 1'b1); check("cmp_rm3", 32'h0, 5'h00);

        // Integer -> float
        issue(op_i2f, 32'h01000001, 32'h0, 3'd0, 1'b1); check("i2f_rne", 32'h4B800000, 5'h01);
        issue(op_i2f, 32'h01000001, 32'h0, 3'd3, 1'b1); check("i2f_rup", 32'h4B800001, 5'h01);
        issue(op_u2f, 32'hFFFFFFFF, 32'h0, 3'd1, 1'b1); check("u2f_rtz", 32'h4F7FFFFF, 5'h01);
        issue(op_u2f, 32'hFFFFFFFF, 32'h0, 3'd0, 1'b1); check("u2f_rne", 32'h4F800000, 5'h01);
        issue(op_i2f, 32'hFFFFFFFF, 32'h0, 3'd0, 1'b1); check("i2f_m1", 32'hBF800000, 5'h00);
        issue(op_i2f, 32'h00000000, 32'h0, 3'd2, 1'b1); check("i2f_zero", 32'h00000000, 5'h00);
        issue(op_i2f, 32'h80000000, 32'h0, 3'd0, 1'b1); check("i2f_min", 32'hCF000000, 5'h00);

        // Float -> integer
        issue(op_f2i, 32'h4F000000, 32'h0, 3'd0, 1'b1); check("f2i_ovf", 32'h7FFFFFFF, 5'h10);
        issue(op_f2i, 32'hBFC00000, 32'h0, 3'd0, 1'b1); check("f2i_m1p5_rne", 32'hFFFFFFFE, 5'h01);
        issue(op_f2i, 32'hBFC00000, 32'h0, 3'd1, 1'b1); check("f2i_m1p5_rtz", 32'hFFFFFFFF, 5'h01);
        issue(op_f2i_c2, 32'hBFC00000, 32'h0, 3'd0, 1'b1); check("f2i_cop2", 32'hFFFFFFFE, 5'h01);
        issue(op_f2i, 32'h40200000, 32'h0, 3'd0, 1'b1); check("f2i_2p5_rne", 32'h00000002, 5'h01);
        issue(op_f2i, 32'h40200000, 32'h0, 3'd4, 1'b1); check("f2i_2p5_rmm", 32'h00000003, 5'h01);
        issue(op_f2i, 32'hCF000000, 32'h0, 3'd0, 1'b1); check("f2i_min", 32'h80000000, 5'h00);
        issue(op_f2i, 32'hFF800000, 32'h0, 3'd0, 1'b1); check("f2i_ninf", 32'h80000000, 5'h10);
        issue(op_f2i, 32'h7FC00000, 32'h0, 3'd0, 1'b1); check("f2i_nan", 32'h7FFFFFFF, 5'h10);
        issue(op_f2u, 32'h7FC00000, 32'h0, 3'd0, 1'b1); check("f2u_nan", 32'hFFFFFFFF, 5'h10);
        issue(op_f2u, 32'hBF800000, 32'h0, 3'd0, 1'b1); check("f2u_m1", 32'h00000000, 5'h10);
        issue(op_f2u, 32'hBE99999A, 32'h0, 3'd1, 1'b1); check("f2u_m0p3", 32'h00000000, 5'h01);
        issue(op_f2u, 32'h4F800000, 32'h0, 3'd0, 1'b1); check("f2u_ovf", 32'hFFFFFFFF, 5'h10);
        issue(op_f2i, 32'h00000001, 32'h0, 3'd3, 1'b1); check("f2i_denorm_rup", 32'h00000001, 5'h01);

        // Disabled / unsupported / multiple ops
        issue(op_f2i, 32'h4F000000, 32'h0, 3'd0, 1'b0); check("disabled", 32'h0, 5'h00);
        issue(op_fadd, 32'h3F800000, 32'h3F800000, 3'd0, 1'b1); check("fadd", 32'h0, 5'h00);
`ifdef FP_UNIT_ONEHOT_CHECK_EN
        issue(op_two, 32'h3F800000, 32'h40000000, 3'd1, 1'b1); check("multi_op", 32'h0, 5'h10);
`else
        issue(op_two, 32'h3F800000, 32'h40000000, 3'd1, 1'b1); check("multi_op", 32'h1, 5'h00);
`endif

        // Asynchronous reset mid-stream
        issue(op_f2i, 32'hBFC00000, 32'h0, 3'd0, 1'b1); check("pre_reset", 32'hFFFFFFFE, 5'h01);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", 32'h0, 5'h00);
        @(negedge clock);
        reset = 1'b0;
        issue(op_i2f, 32'h01000001, 32'h0, 3'd3, 1'b1); check("post_reset", 32'h4B800001, 5'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
